// File: rtl/rs_issue_scheduler_if.sv
// Dispatch, CDB and issue signals of the reservation-station scheduler.
// The master drives dispatch/CDB/flush/issue_ready; the slave is the scheduler.
interface rs_issue_scheduler_if #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned ROB_W   = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 5
) ();
    localparam int unsigned CntW = $clog2(ENTRIES) + 1;

    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [ROB_W-1:0]  disp_rob_idx;
    logic              disp_a_wait;
    logic [ROB_W-1:0]  disp_a_tag;
    logic [DATA_W-1:0] disp_a_value;
    logic              disp_b_wait;
    logic [ROB_W-1:0]  disp_b_tag;
    logic [DATA_W-1:0] disp_b_value;
    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [ROB_W-1:0]  issue_rob_idx;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic [CntW-1:0]   count;

    modport master (
        output flush, disp_valid, disp_op, disp_rob_idx,
               disp_a_wait, disp_a_tag, disp_a_value,
               disp_b_wait, disp_b_tag, disp_b_value,
               cdb_valid, cdb_tag, cdb_value, issue_ready,
        input  disp_ready, issue_valid, issue_op, issue_rob_idx, issue_a, issue_b, count
    );

    modport slave (
        input  flush, disp_valid, disp_op, disp_rob_idx,
               disp_a_wait, disp_a_tag, disp_a_value,
               disp_b_wait, disp_b_tag, disp_b_value,
               cdb_valid, cdb_tag, cdb_value, issue_ready,
        output disp_ready, issue_valid, issue_op, issue_rob_idx, issue_a, issue_b, count
    );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Reservation station: holds dispatched ops, wakes operands from the CDB and
// issues the oldest fully-ready entry (age-matrix select) to one functional unit.
module rs_issue_scheduler #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned ROB_W   = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 5
) (
    input logic                clk,
    input logic                rst,
    rs_issue_scheduler_if.slave bus
);
    localparam int unsigned CntW = $clog2(ENTRIES) + 1;
    localparam int unsigned IdxW = $clog2(ENTRIES);

    logic [ENTRIES-1:0]              valid_q, valid_d;
    logic [ENTRIES-1:0]              a_wait_q, a_wait_d, b_wait_q, b_wait_d;
    logic [ENTRIES-1:0][OP_W-1:0]    op_q, op_d;
    logic [ENTRIES-1:0][ROB_W-1:0]   rob_q, rob_d;
    logic [ENTRIES-1:0][ROB_W-1:0]   a_tag_q, a_tag_d, b_tag_q, b_tag_d;
    logic [ENTRIES-1:0][DATA_W-1:0]  a_val_q, a_val_d, b_val_q, b_val_d;
    // older_q[i][j] = 1: entry j was allocated before entry i.
    logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;
    logic [CntW-1:0]                 count_q, count_d;

    logic [ENTRIES-1:0] ready, sel_oh;
    logic [IdxW-1:0]    sel_idx, free_idx;
    logic               issue_valid, disp_ready, fire, accept, a_snoop, b_snoop;

    always_comb begin
        ready   = valid_q & ~a_wait_q & ~b_wait_q;
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            sel_oh[i] = ready[i] && ((older_q[i] & ready) == '0);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (sel_oh[i]) sel_idx = IdxW'(i);
        end
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IdxW'(i);
        end

        issue_valid = !rst && (sel_oh != '0);
        disp_ready  = !rst && (count_q < CntW'(ENTRIES));
        fire        = issue_valid && bus.issue_ready;
        accept      = bus.disp_valid && disp_ready;

        bus.issue_valid   = issue_valid;
        bus.disp_ready    = disp_ready;
        bus.count         = count_q;
        bus.issue_op      = issue_valid ? op_q[sel_idx]    : '0;
        bus.issue_rob_idx = issue_valid ? rob_q[sel_idx]   : '0;
        bus.issue_a       = issue_valid ? a_val_q[sel_idx] : '0;
        bus.issue_b       = issue_valid ? b_val_q[sel_idx] : '0;
    end

    always_comb begin
        valid_d  = valid_q;
        a_wait_d = a_wait_q;
        b_wait_d = b_wait_q;
        op_d     = op_q;
        rob_d    = rob_q;
        a_tag_d  = a_tag_q;
        b_tag_d  = b_tag_q;
        a_val_d  = a_val_q;
        b_val_d  = b_val_q;
        older_d  = older_q;
        count_d  = count_q + CntW'(accept) - CntW'(fire);

        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && bus.cdb_valid) begin
                if (a_wait_q[i] && a_tag_q[i] == bus.cdb_tag) begin
                    a_wait_d[i] = 1'b0;
                    a_val_d[i]  = bus.cdb_value;
                end
                if (b_wait_q[i] && b_tag_q[i] == bus.cdb_tag) begin
                    b_wait_d[i] = 1'b0;
                    b_val_d[i]  = bus.cdb_value;
                end
            end
        end

        if (fire) valid_d[sel_idx] = 1'b0;

        // Snoop the CDB at dispatch so a same-cycle broadcast is not lost.
        a_snoop = bus.cdb_valid && bus.disp_a_wait && (bus.disp_a_tag == bus.cdb_tag);
        b_snoop = bus.cdb_valid && bus.disp_b_wait && (bus.disp_b_tag == bus.cdb_tag);
        if (accept) begin
            valid_d[free_idx]  = 1'b1;
            op_d[free_idx]     = bus.disp_op;
            rob_d[free_idx]    = bus.disp_rob_idx;
            a_tag_d[free_idx]  = bus.disp_a_tag;
            b_tag_d[free_idx]  = bus.disp_b_tag;
            a_wait_d[free_idx] = bus.disp_a_wait && !a_snoop;
            b_wait_d[free_idx] = bus.disp_b_wait && !b_snoop;
            a_val_d[free_idx]  = a_snoop ? bus.cdb_value : bus.disp_a_value;
            b_val_d[free_idx]  = b_snoop ? bus.cdb_value : bus.disp_b_value;
            older_d[free_idx]  = valid_q;
            for (int r = 0; r < ENTRIES; r++) begin
                older_d[r][free_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            valid_q <= '0;
            older_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            older_q <= older_d;
            count_q <= count_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        a_wait_q <= a_wait_d;
        b_wait_q <= b_wait_d;
        op_q     <= op_d;
        rob_q    <= rob_d;
        a_tag_q  <= a_tag_d;
        b_tag_q  <= b_tag_d;
        a_val_q  <= a_val_d;
        b_val_q  <= b_val_d;
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: directed scenarios plus a
// randomized run against an allocation-ordered queue model.
module tb_rs_issue_scheduler;
    localparam int unsigned ENTRIES = 4;
    localparam int unsigned ROB_W   = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rs_issue_scheduler_if #(
        .ENTRIES(ENTRIES), .ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W)
    ) bus ();

    rs_issue_scheduler #(
        .ENTRIES(ENTRIES), .ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [ROB_W-1:0]  rob;
        bit                aw;
        logic [ROB_W-1:0]  at;
        logic [DATA_W-1:0] av;
        bit                bw;
        logic [ROB_W-1:0]  bt;
        logic [DATA_W-1:0] bv;
    } ent_t;

    ent_t model_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush        = 1'b0;
        bus.disp_valid   = 1'b0;
        bus.disp_op      = '0;
        bus.disp_rob_idx = '0;
        bus.disp_a_wait  = 1'b0;
        bus.disp_a_tag   = '0;
        bus.disp_a_value = '0;
        bus.disp_b_wait  = 1'b0;
        bus.disp_b_tag   = '0;
        bus.disp_b_value = '0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_tag      = '0;
        bus.cdb_value    = '0;
        bus.issue_ready  = 1'b0;
    endtask

    task automatic drive_disp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                              input bit aw, input logic [ROB_W-1:0] at,
                              input logic [DATA_W-1:0] av, input bit bw,
                              input logic [ROB_W-1:0] bt, input logic [DATA_W-1:0] bv);
        bus.disp_valid   = 1'b1;
        bus.disp_op      = op;
        bus.disp_rob_idx = rob;
        bus.disp_a_wait  = aw;
        bus.disp_a_tag   = at;
        bus.disp_a_value = av;
        bus.disp_b_wait  = bw;
        bus.disp_b_tag   = bt;
        bus.disp_b_value = bv;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tests++;
        if (bus.disp_ready !== 1'b0) begin
            fails++; $display("FAIL reset_disp_ready got=%0b exp=0", bus.disp_ready);
        end
        tests++;
        if (bus.issue_valid !== 1'b0) begin
            fails++; $display("FAIL reset_issue_valid got=%0b exp=0", bus.issue_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (bus.disp_ready !== 1'b1) begin
            fails++; $display("FAIL idle_disp_ready got=%0b exp=1", bus.disp_ready);
        end
        tests++;
        if (bus.count !== 3'd0) begin
            fails++; $display("FAIL idle_count got=%0d exp=0", bus.count);
        end
        tests++;
        if (bus.issue_valid !== 1'b0 || bus.issue_a !== 32'h0) begin
            fails++;
            $display("FAIL idle_issue got=%0b/%h exp=0/0", bus.issue_valid, bus.issue_a);
        end
    endtask

    task automatic test_ready_dispatch();
        drive_disp(5'd3, 3'd5, 1'b0, 3'd0, 32'h10, 1'b0, 3'd0, 32'h20);
        bus.issue_ready = 1'b1;
        tick();
        bus.disp_valid = 1'b0;
        tests++;
        if (bus.issue_valid !== 1'b1 || bus.issue_op !== 5'd3 || bus.issue_rob_idx !== 3'd5 ||
            bus.issue_a !== 32'h10 || bus.issue_b !== 32'h20) begin
            fails++;
            $display("FAIL ready_dispatch got v=%0b op=%0d rob=%0d a=%h b=%h exp 1/3/5/10/20",
                     bus.issue_valid, bus.issue_op, bus.issue_rob_idx, bus.issue_a, bus.issue_b);
        end
        tick();
        tests++;
        if (bus.count !== 3'd0 || bus.issue_valid !== 1'b0) begin
            fails++;
            $display("FAIL ready_drain got count=%0d v=%0b exp 0/0", bus.count, bus.issue_valid);
        end
        idle_inputs();
    endtask

    task automatic test_wakeup();
        bus.issue_ready = 1'b1;
        drive_disp(5'd1, 3'd3, 1'b1, 3'd2, 32'hBAD0, 1'b0, 3'd0, 32'h5);
        tick();
        bus.disp_valid = 1'b0;
        tests++;
        if (bus.issue_valid !== 1'b0) begin
            fails++; $display("FAIL wakeup_pending got=%0b exp=0", bus.issue_valid);
        end
        tick();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd2;
        bus.cdb_value = 32'hDEAD;
        tick();
        bus.cdb_valid = 1'b0;
        tests++;
        if (bus.issue_valid !== 1'b1 || bus.issue_a !== 32'hDEAD || bus.issue_b !== 32'h5) begin
            fails++;
            $display("FAIL wakeup_issue got v=%0b a=%h b=%h exp 1/dead/5",
                     bus.issue_valid, bus.issue_a, bus.issue_b);
        end
        tick();
        // Dispatch and matching broadcast in the same cycle.
        drive_disp(5'd2, 3'd4, 1'b1, 3'd2, 32'hBAD1, 1'b0, 3'd0, 32'h6);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd2;
        bus.cdb_value = 32'hDEAD;
        tick();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
        tests++;
        if (bus.issue_valid !== 1'b1 || bus.issue_a !== 32'hDEAD || bus.issue_rob_idx !== 3'd4)
        begin
            fails++;
            $display("FAIL dispatch_snoop got v=%0b a=%h rob=%0d exp 1/dead/4",
                     bus.issue_valid, bus.issue_a, bus.issue_rob_idx);
        end
        tick();
        tests++;
        if (bus.count !== 3'd0) begin
            fails++; $display("FAIL wakeup_drain got count=%0d exp=0", bus.count);
        end
        idle_inputs();
    endtask

    task automatic test_age_backpressure();
        bus.issue_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive_disp(5'(k), 3'(k), 1'b0, 3'd0, 32'(k * 16), 1'b0, 3'd0, 32'(k));
            tick();
        end
        bus.disp_valid = 1'b0;
        tests++;
        if (bus.count !== 3'd4 || bus.disp_ready !== 1'b0 || bus.issue_rob_idx !== 3'd1) begin
            fails++;
            $display("FAIL full_stall got count=%0d rdy=%0b rob=%0d exp 4/0/1",
                     bus.count, bus.disp_ready, bus.issue_rob_idx);
        end
        // A fire while full must not open a slot in the same cycle.
        bus.issue_ready = 1'b1;
        drive_disp(5'd9, 3'd6, 1'b0, 3'd0, 32'h66, 1'b0, 3'd0, 32'h66);
        #1;
        tests++;
        if (bus.disp_ready !== 1'b0) begin
            fails++; $display("FAIL full_fire_ready got=%0b exp=0", bus.disp_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            tests++;
            if (bus.issue_valid !== 1'b1 || bus.issue_rob_idx !== 3'(k)) begin
                fails++;
                $display("FAIL age_order got v=%0b rob=%0d exp 1/%0d",
                         bus.issue_valid, bus.issue_rob_idx, k);
            end
            tick();
            bus.disp_valid = 1'b0;
            if (k == 1) begin
                tests++;
                if (bus.disp_ready !== 1'b1 || bus.count !== 3'd3) begin
                    fails++;
                    $display("FAIL after_first_fire got rdy=%0b count=%0d exp 1/3",
                             bus.disp_ready, bus.count);
                end
            end
        end
        tests++;
        if (bus.count !== 3'd0 || bus.issue_valid !== 1'b0) begin
            fails++;
            $display("FAIL age_drain got count=%0d v=%0b exp 0/0", bus.count, bus.issue_valid);
        end
        idle_inputs();
    endtask

    task automatic test_out_of_order();
        bus.issue_ready = 1'b0;
        drive_disp(5'd1, 3'd1, 1'b1, 3'd7, 32'h0, 1'b0, 3'd0, 32'h1);
        tick();
        drive_disp(5'd2, 3'd2, 1'b0, 3'd0, 32'h22, 1'b0, 3'd0, 32'h2);
        tick();
        bus.disp_valid = 1'b0;
        tests++;
        if (bus.issue_valid !== 1'b1 || bus.issue_rob_idx !== 3'd2) begin
            fails++;
            $display("FAIL ooo_first got v=%0b rob=%0d exp 1/2", bus.issue_valid, bus.issue_rob_idx);
        end
        bus.issue_ready = 1'b1;
        tick();
        tests++;
        if (bus.issue_valid !== 1'b0 || bus.count !== 3'd1) begin
            fails++;
            $display("FAIL ooo_wait got v=%0b count=%0d exp 0/1", bus.issue_valid, bus.count);
        end
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd7;
        bus.cdb_value = 32'h77;
        tick();
        bus.cdb_valid = 1'b0;
        tests++;
        if (bus.issue_valid !== 1'b1 || bus.issue_rob_idx !== 3'd1 || bus.issue_a !== 32'h77) begin
            fails++;
            $display("FAIL ooo_second got v=%0b rob=%0d a=%h exp 1/1/77",
                     bus.issue_valid, bus.issue_rob_idx, bus.issue_a);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        bus.issue_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive_disp(5'(k), 3'(k), 1'b0, 3'd0, 32'(k), 1'b0, 3'd0, 32'(k));
            tick();
        end
        drive_disp(5'd4, 3'd4, 1'b0, 3'd0, 32'h4, 1'b0, 3'd0, 32'h4);
        bus.flush = 1'b1;
        tick();
        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        tests++;
        if (bus.count !== 3'd0 || bus.issue_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush got count=%0d v=%0b rdy=%0b exp 0/0/1",
                     bus.count, bus.issue_valid, bus.disp_ready);
        end
        tick();
        tests++;
        if (bus.issue_valid !== 1'b0) begin
            fails++; $display("FAIL flush_absent got v=%0b exp=0", bus.issue_valid);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int   sel;
        bit   exp_valid, fire, accept;
        ent_t e;
        model_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle_inputs();
            bus.issue_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                drive_disp(5'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), $urandom,
                           1'($urandom), 3'($urandom), $urandom);
            end
            if ($urandom_range(0, 1) != 0) begin
                bus.cdb_valid = 1'b1;
                bus.cdb_value = $urandom;
                if (model_q.size() > 0 && $urandom_range(0, 2) != 0)
                    bus.cdb_tag = model_q[$urandom_range(0, model_q.size() - 1)].at;
                else
                    bus.cdb_tag = 3'($urandom);
            end
            bus.flush = ($urandom_range(0, 49) == 0);
            #1;

            // Oldest ready entry = first ready one in allocation order.
            sel = -1;
            for (int i = 0; i < model_q.size(); i++) begin
                if (sel < 0 && !model_q[i].aw && !model_q[i].bw) sel = i;
            end
            exp_valid = (sel >= 0);
            tests++;
            if (bus.count !== 3'(model_q.size()) ||
                bus.disp_ready !== (model_q.size() < ENTRIES)) begin
                fails++;
                $display("FAIL rand_occupancy cyc=%0d got count=%0d rdy=%0b exp %0d/%0b", cyc,
                         bus.count, bus.disp_ready, model_q.size(), model_q.size() < ENTRIES);
            end
            tests++;
            if (exp_valid) begin
                if (bus.issue_valid !== 1'b1 || bus.issue_op !== model_q[sel].op ||
                    bus.issue_rob_idx !== model_q[sel].rob || bus.issue_a !== model_q[sel].av ||
                    bus.issue_b !== model_q[sel].bv) begin
                    fails++;
                    $display("FAIL rand_issue cyc=%0d got v=%0b op=%0d rob=%0d a=%h b=%h exp 1/%0d/%0d/%h/%h",
                             cyc, bus.issue_valid, bus.issue_op, bus.issue_rob_idx, bus.issue_a,
                             bus.issue_b, model_q[sel].op, model_q[sel].rob, model_q[sel].av,
                             model_q[sel].bv);
                end
            end else if (bus.issue_valid !== 1'b0 || bus.issue_op !== '0 ||
                         bus.issue_rob_idx !== '0 || bus.issue_a !== '0 || bus.issue_b !== '0) begin
                fails++;
                $display("FAIL rand_idle cyc=%0d got v=%0b a=%h b=%h exp all zero",
                         cyc, bus.issue_valid, bus.issue_a, bus.issue_b);
            end

            fire   = exp_valid && bus.issue_ready;
            accept = bus.disp_valid && (model_q.size() < ENTRIES);
            if (bus.flush) begin
                model_q.delete();
            end else begin
                if (fire) model_q.delete(sel);
                if (bus.cdb_valid) begin
                    for (int i = 0; i < model_q.size(); i++) begin
                        if (model_q[i].aw && model_q[i].at == bus.cdb_tag) begin
                            model_q[i].aw = 1'b0;
                            model_q[i].av = bus.cdb_value;
                        end
                        if (model_q[i].bw && model_q[i].bt == bus.cdb_tag) begin
                            model_q[i].bw = 1'b0;
                            model_q[i].bv = bus.cdb_value;
                        end
                    end
                end
                if (accept) begin
                    e.op = bus.disp_op;
                    e.rob = bus.disp_rob_idx;
                    e.at = bus.disp_a_tag;
                    e.bt = bus.disp_b_tag;
                    e.aw = bus.disp_a_wait;
                    e.av = bus.disp_a_value;
                    e.bw = bus.disp_b_wait;
                    e.bv = bus.disp_b_value;
                    if (e.aw && bus.cdb_valid && e.at == bus.cdb_tag) begin
                        e.aw = 1'b0;
                        e.av = bus.cdb_value;
                    end
                    if (e.bw && bus.cdb_valid && e.bt == bus.cdb_tag) begin
                        e.bw = 1'b0;
                        e.bv = bus.cdb_value;
                    end
                    model_q.push_back(e);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_age_backpressure();
        test_out_of_order();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
